// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : Execute-to-memory pipeline register.
//               - Resolves branch/jump redirects from the ALU flags.
//               - Registers the ALU result, store data and control bits.
//               - Supports stall and flush.
//               - Keeps saturating branch statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_valid,
   input  logic [WIDTH-1:0]     alu_out,
   input  logic [3:0]           flags,
   input  logic [WIDTH-1:0]     rs2_data,
   input  logic [4:0]           rd,
   input  logic [2:0]           funct3,
   input  logic                 branch,
   input  logic                 jump,
   input  logic                 reg_write,
   input  logic                 mem_write,
   input  logic [1:0]           result_src,
   input  logic [WIDTH-1:0]     pc_plus4,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 pc_src,
   output logic                 m_valid,
   output logic [WIDTH-1:0]     m_alu_out,
   output logic [WIDTH-1:0]     m_write_data,
   output logic [4:0]           m_rd,
   output logic                 m_reg_write,
   output logic                 m_mem_write,
   output logic [1:0]           m_result_src,
   output logic [WIDTH-1:0]     m_pc_plus4,
   output logic                 m_illegal_br,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] br_taken_count
);

   localparam logic [2:0] c_BEQ  = 3'b000;
   localparam logic [2:0] c_BNE  = 3'b001;
   localparam logic [2:0] c_BLT  = 3'b100;
   localparam logic [2:0] c_BGE  = 3'b101;
   localparam logic [2:0] c_BLTU = 3'b110;
   localparam logic [2:0] c_BGEU = 3'b111;

   logic w_zero, w_sign, w_carry, w_ovf;
   logic w_cond;
   logic w_illegal_f3;
   logic w_adv;
   logic w_bc_max, w_btc_max;

   logic                 r_valid;
   logic [WIDTH-1:0]     r_alu_out;
   logic [WIDTH-1:0]     r_write_data;
   logic [4:0]           r_rd;
   logic                 r_reg_write;
   logic                 r_mem_write;
   logic [1:0]           r_result_src;
   logic [WIDTH-1:0]     r_pc_plus4;
   logic                 r_illegal_br;
   logic [CNT_WIDTH-1:0] r_br_count;
   logic [CNT_WIDTH-1:0] r_br_taken_count;

   assign {w_zero, w_sign, w_carry, w_ovf} = flags;

   // funct3 010/011 are not branch encodings
   assign w_illegal_f3 = (funct3[2:1] == 2'b01);

   // Branch condition decode from the SUB flags; illegal encodings never take
   always_comb begin
      w_cond = 1'b0;
      case (funct3)
         c_BEQ:   w_cond = w_zero;
         c_BNE:   w_cond = ~w_zero;
         c_BLT:   w_cond = w_sign ^ w_ovf;
         c_BGE:   w_cond = ~(w_sign ^ w_ovf);
         c_BLTU:  w_cond = w_carry;
         c_BGEU:  w_cond = ~w_carry;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_adv     = ex_valid & ~stall & ~flush;
   assign pc_src    = w_adv & (jump | (branch & w_cond));
   assign w_bc_max  = &r_br_count;
   assign w_btc_max = &r_br_taken_count;

   // Pipeline register: flush clears, stall holds, otherwise load from execute
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_alu_out    <= '0;
         r_write_data <= '0;
         r_rd         <= '0;
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= '0;
         r_pc_plus4   <= '0;
         r_illegal_br <= 1'b0;
      end else if (flush) begin
         r_valid      <= 1'b0;
         r_alu_out    <= '0;
         r_write_data <= '0;
         r_rd         <= '0;
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= '0;
         r_pc_plus4   <= '0;
         r_illegal_br <= 1'b0;
      end else if (!stall) begin
         r_valid      <= ex_valid;
         r_alu_out    <= alu_out;
         r_write_data <= rs2_data;
         r_rd         <= rd;
         r_reg_write  <= reg_write & ex_valid;
         r_mem_write  <= mem_write & ex_valid;
         r_result_src <= result_src;
         r_pc_plus4   <= pc_plus4;
         r_illegal_br <= ex_valid & branch & w_illegal_f3;
      end
   end

   // Saturating branch statistics; only branches that actually advance count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_count       <= '0;
         r_br_taken_count <= '0;
      end else if (w_adv && branch) begin
         if (!w_bc_max) begin
            r_br_count <= r_br_count + 1'b1;
         end
         if (w_cond && !w_btc_max) begin
            r_br_taken_count <= r_br_taken_count + 1'b1;
         end
      end
   end

   assign m_valid        = r_valid;
   assign m_alu_out      = r_alu_out;
   assign m_write_data   = r_write_data;
   assign m_rd           = r_rd;
   assign m_reg_write    = r_reg_write;
   assign m_mem_write    = r_mem_write;
   assign m_result_src   = r_result_src;
   assign m_pc_plus4     = r_pc_plus4;
   assign m_illegal_br   = r_illegal_br;
   assign br_count       = r_br_count;
   assign br_taken_count = r_br_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Scoreboard testbench for ex_mem_stage (CNT_WIDTH = 4 so that
//               counter saturation is reachable with a short sequence).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

   localparam int WIDTH     = 32;
   localparam int CNT_WIDTH = 4;
   localparam logic [CNT_WIDTH-1:0] c_CMAX = {CNT_WIDTH{1'b1}};

   logic                 clk;
   logic                 rst_n;
   logic                 ex_valid;
   logic [WIDTH-1:0]     alu_out;
   logic [3:0]           flags;
   logic [WIDTH-1:0]     rs2_data;
   logic [4:0]           rd;
   logic [2:0]           funct3;
   logic                 branch;
   logic                 jump;
   logic                 reg_write;
   logic                 mem_write;
   logic [1:0]           result_src;
   logic [WIDTH-1:0]     pc_plus4;
   logic                 stall;
   logic                 flush;
   logic                 pc_src;
   logic                 m_valid;
   logic [WIDTH-1:0]     m_alu_out;
   logic [WIDTH-1:0]     m_write_data;
   logic [4:0]           m_rd;
   logic                 m_reg_write;
   logic                 m_mem_write;
   logic [1:0]           m_result_src;
   logic [WIDTH-1:0]     m_pc_plus4;
   logic                 m_illegal_br;
   logic [CNT_WIDTH-1:0] br_count;
   logic [CNT_WIDTH-1:0] br_taken_count;

   ex_mem_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .alu_out        (alu_out),
      .flags          (flags),
      .rs2_data       (rs2_data),
      .rd             (rd),
      .funct3         (funct3),
      .branch         (branch),
      .jump           (jump),
      .reg_write      (reg_write),
      .mem_write      (mem_write),
      .result_src     (result_src),
      .pc_plus4       (pc_plus4),
      .stall          (stall),
      .flush          (flush),
      .pc_src         (pc_src),
      .m_valid        (m_valid),
      .m_alu_out      (m_alu_out),
      .m_write_data   (m_write_data),
      .m_rd           (m_rd),
      .m_reg_write    (m_reg_write),
      .m_mem_write    (m_mem_write),
      .m_result_src   (m_result_src),
      .m_pc_plus4     (m_pc_plus4),
      .m_illegal_br   (m_illegal_br),
      .br_count       (br_count),
      .br_taken_count (br_taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] alu;
      logic [3:0]  fl;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        br;
      logic        jmp;
      logic        rw;
      logic        mw;
      logic [1:0]  rs;
      logic [31:0] pc4;
      logic        st;
      logic        fl_k;
      logic        exp_pc;   // hand-computed redirect
      logic        exp_cond; // hand-computed branch condition
   } vec_t;

   typedef struct {
      logic                 valid;
      logic [31:0]          alu;
      logic [31:0]          wd;
      logic [4:0]           rd;
      logic                 rw;
      logic                 mw;
      logic [1:0]           rs;
      logic [31:0]          pc4;
      logic                 ill;
      logic [CNT_WIDTH-1:0] bc;
      logic [CNT_WIDTH-1:0] btc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t nop();
      vec_t v;
      v = '{v:1'b0, alu:32'h0, fl:4'h0, rs2:32'h0, rd:5'd0, f3:3'b000, br:1'b0,
            jmp:1'b0, rw:1'b0, mw:1'b0, rs:2'b00, pc4:32'h0, st:1'b0, fl_k:1'b0,
            exp_pc:1'b0, exp_cond:1'b0};
      return v;
   endfunction

   function automatic exp_t zero_state();
      exp_t z;
      z = '{valid:1'b0, alu:32'h0, wd:32'h0, rd:5'd0, rw:1'b0, mw:1'b0, rs:2'b00,
            pc4:32'h0, ill:1'b0, bc:'0, btc:'0};
      return z;
   endfunction

   // Drive one vector at the falling edge, check pc_src, queue the next state
   task automatic step(input vec_t v, input string name);
      @(negedge clk);
      ex_valid   = v.v;    alu_out  = v.alu;  flags     = v.fl;  rs2_data  = v.rs2;
      rd         = v.rd;   funct3   = v.f3;   branch    = v.br;  jump      = v.jmp;
      reg_write  = v.rw;   mem_write = v.mw;  result_src = v.rs; pc_plus4  = v.pc4;
      stall      = v.st;   flush    = v.fl_k;
      #1;
      chk({name, ".pc_src"}, {31'b0, pc_src}, {31'b0, v.exp_pc});
      if (v.fl_k) begin
         e.valid = 0; e.alu = 0; e.wd = 0; e.rd = 0; e.rw = 0; e.mw = 0;
         e.rs = 0; e.pc4 = 0; e.ill = 0;
      end else if (!v.st) begin
         e.valid = v.v;  e.alu = v.alu; e.wd = v.rs2; e.rd = v.rd;
         e.rw = v.rw & v.v; e.mw = v.mw & v.v; e.rs = v.rs; e.pc4 = v.pc4;
         e.ill = v.v & v.br & (v.f3 == 3'b010 || v.f3 == 3'b011);
         if (v.v && v.br) begin
            if (e.bc != c_CMAX) e.bc = e.bc + 1'b1;
            if (v.exp_cond && e.btc != c_CMAX) e.btc = e.btc + 1'b1;
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare the registered outputs one delta after each rising edge
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("m_valid",        {31'b0, m_valid},      {31'b0, x.valid});
         chk("m_alu_out",      m_alu_out,             x.alu);
         chk("m_write_data",   m_write_data,          x.wd);
         chk("m_rd",           {27'b0, m_rd},         {27'b0, x.rd});
         chk("m_reg_write",    {31'b0, m_reg_write},  {31'b0, x.rw});
         chk("m_mem_write",    {31'b0, m_mem_write},  {31'b0, x.mw});
         chk("m_result_src",   {30'b0, m_result_src}, {30'b0, x.rs});
         chk("m_pc_plus4",     m_pc_plus4,            x.pc4);
         chk("m_illegal_br",   {31'b0, m_illegal_br}, {31'b0, x.ill});
         chk("br_count",       {28'b0, br_count},       {28'b0, x.bc});
         chk("br_taken_count", {28'b0, br_taken_count}, {28'b0, x.btc});
      end
   end

   task automatic chk_all_zero(input string name);
      chk({name, ".m_valid"},   {31'b0, m_valid},     32'h0);
      chk({name, ".m_alu_out"}, m_alu_out,            32'h0);
      chk({name, ".m_wd"},      m_write_data,         32'h0);
      chk({name, ".m_rd"},      {27'b0, m_rd},        32'h0);
      chk({name, ".m_rw"},      {31'b0, m_reg_write}, 32'h0);
      chk({name, ".m_mw"},      {31'b0, m_mem_write}, 32'h0);
      chk({name, ".m_rs"},      {30'b0, m_result_src}, 32'h0);
      chk({name, ".m_pc4"},     m_pc_plus4,           32'h0);
      chk({name, ".m_ill"},     {31'b0, m_illegal_br}, 32'h0);
      chk({name, ".bc"},        {28'b0, br_count},     32'h0);
      chk({name, ".btc"},       {28'b0, br_taken_count}, 32'h0);
   endtask

   initial begin
      vec_t v;
      int   guard;
      ex_valid = 0; alu_out = 0; flags = 0; rs2_data = 0; rd = 0; funct3 = 0;
      branch = 0; jump = 0; reg_write = 0; mem_write = 0; result_src = 0;
      pc_plus4 = 0; stall = 0; flush = 0;
      e = zero_state();

      // Asynchronous reset before the first clock edge
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset0");
      #1 rst_n = 1'b1;

      // BEQ taken
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b000; v.fl = 4'b1000;
      v.alu = 32'h0; v.rd = 5'd3; v.pc4 = 32'h104; v.rs = 2'b10; v.rs2 = 32'hAAAA_5555;
      v.exp_pc = 1; v.exp_cond = 1;
      step(v, "beq_taken");

      // BLT with S=1,V=1 -> not taken
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b100; v.fl = 4'b0101;
      v.alu = 32'h8000_0001; v.pc4 = 32'h108;
      v.exp_pc = 0; v.exp_cond = 0;
      step(v, "blt_nt");

      // BLTU with C=1 -> taken
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b110; v.fl = 4'b0010;
      v.alu = 32'hFFFF_FFF0; v.pc4 = 32'h10C;
      v.exp_pc = 1; v.exp_cond = 1;
      step(v, "bltu_t");

      // BNE with Z=1 -> not taken
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b001; v.fl = 4'b1000;
      v.exp_pc = 0; v.exp_cond = 0;
      step(v, "bne_nt");

      // BGE with S=1,V=0 -> not taken
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b101; v.fl = 4'b0100;
      v.exp_pc = 0; v.exp_cond = 0;
      step(v, "bge_nt");

      // BGEU with C=0 -> taken
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b111; v.fl = 4'b0000;
      v.exp_pc = 1; v.exp_cond = 1;
      step(v, "bgeu_t");

      // Plain store/ALU op loading 0x1234
      v = nop(); v.v = 1; v.alu = 32'h1234; v.rs2 = 32'hDEAD_BEEF; v.rd = 5'd7;
      v.rw = 1; v.mw = 1; v.rs = 2'b01; v.pc4 = 32'h200;
      step(v, "load1234");

      // Stall for three cycles with a would-be-taken BEQ present
      for (int i = 0; i < 3; i++) begin
         v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b000; v.fl = 4'b1000; v.st = 1;
         v.alu = 32'h5555; v.rw = 1; v.exp_pc = 0; v.exp_cond = 1;
         step(v, "stall");
      end

      // Flush together with stall clears the stage
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b000; v.fl = 4'b1000; v.st = 1; v.fl_k = 1;
      v.alu = 32'h7777; v.rw = 1; v.exp_pc = 0; v.exp_cond = 1;
      step(v, "flush");

      // Illegal funct3 branch
      v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b010; v.fl = 4'b1000; v.alu = 32'h42;
      v.exp_pc = 0; v.exp_cond = 0;
      step(v, "illegal");

      // Jump alone redirects, does not count
      v = nop(); v.v = 1; v.jmp = 1; v.rw = 1; v.rd = 5'd1; v.rs = 2'b10; v.pc4 = 32'h304;
      v.exp_pc = 1;
      step(v, "jump");

      // Branch + jump: redirect, branch counted as not taken
      v = nop(); v.v = 1; v.jmp = 1; v.br = 1; v.f3 = 3'b001; v.fl = 4'b1000;
      v.exp_pc = 1; v.exp_cond = 0;
      step(v, "br_jmp");

      // Bubble with write enables and branch asserted
      v = nop(); v.v = 0; v.br = 1; v.f3 = 3'b000; v.fl = 4'b1000; v.rw = 1; v.mw = 1;
      v.alu = 32'h99; v.rd = 5'd9;
      v.exp_pc = 0; v.exp_cond = 1;
      step(v, "bubble");

      // Mid-operation asynchronous reset, checked before the next edge
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("reset_mid");
      e = zero_state();
      #1 rst_n = 1'b1;

      // 20 taken branches saturate both counters at 15
      for (int i = 0; i < 20; i++) begin
         v = nop(); v.v = 1; v.br = 1; v.f3 = 3'b000; v.fl = 4'b1000;
         v.alu = i; v.exp_pc = 1; v.exp_cond = 1;
         step(v, "sat");
      end

      v = nop();
      step(v, "idle");

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
